cmt_bus_bridge: RTL and testbench

Bus-side initiator for the compare-match-timer register block. It accepts single word transactions from the system bus decoder (req/ack handshake) and converts each into a one-cycle register strobe (reg_wen_o or reg_ren_o) plus address and data. For reads it captures the register block's registered read data one cycle after the read strobe. It returns ack_o, or err_o for illegal accesses, and sits between the SoC peripheral bus and the timer register file.

---
 rtl/cmt_bus_bridge.sv | 137 +++++++++++++
 tb/tb_cmt_bus_bridge.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/cmt_bus_bridge.sv
// rtl/cmt_bus_bridge.sv - bus-side initiator for the compare-match-timer register block
//
// Converts single-word req/ack bus transactions into one-cycle register
// strobes for the timer register file and returns ack/err plus read data.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_i           transaction request, held until ack_o
//   we_i            1 = write, 0 = read
//   addr_i          byte offset within the timer window
//   be_i            byte enables (writes must be full-word)
//   wdata_i         write data
//   ack_o           one-cycle completion pulse
//   err_o           qualifies ack_o: access rejected
//   rdata_o         read data, valid with ack_o
//   busy_o          high whenever a transaction is in flight
//   reg_wen_o       one-cycle write strobe to register block
//   reg_ren_o       one-cycle read strobe to register block
//   reg_addr_o      register offset
//   reg_wdata_o     register write data
//   reg_rdata_i     registered read data, valid the cycle after reg_ren_o

module cmt_bus_bridge #(
   parameter int              AW     = 8,
   parameter int              DW     = 32,
   parameter logic [AW-1:0]   MAXOFF = 8'h18
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [3:0]    be_i,
   input  logic [DW-1:0] wdata_i,
   output logic          ack_o,
   output logic          err_o,
   output logic [DW-1:0] rdata_o,
   output logic          busy_o,
   output logic          reg_wen_o,
   output logic          reg_ren_o,
   output logic [AW-1:0] reg_addr_o,
   output logic [DW-1:0] reg_wdata_o,
   input  logic [DW-1:0] reg_rdata_i
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] WR   = 3'd1;
   localparam logic [2:0] RD   = 3'd2;
   localparam logic [2:0] RDW  = 3'd3;
   localparam logic [2:0] ACK  = 3'd4;
   localparam logic [2:0] ERR  = 3'd5;

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          ack_q, ack_d;
   logic          err_q, err_d;
   logic          busy_q, busy_d;
   logic          wen_q, wen_d;
   logic          ren_q, ren_d;
   logic          illegal;

   // Misaligned, out-of-window, or partial-word writes are rejected.
   assign illegal = (addr_i[1:0] != 2'b00) || (addr_i > MAXOFF) ||
                    (we_i && (be_i != 4'hF));

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (req_i) begin
               addr_d  = addr_i;
               wdata_d = wdata_i;
               // WR vs RD carries the captured direction for the rest of the access.
               if (illegal)   state_d = ERR;
               else if (we_i) state_d = WR;
               else           state_d = RD;
            end
         end
         WR:      state_d = ACK;
         RD:      state_d = RDW;
         RDW:     state_d = ACK;
         ACK:     state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so every output is a flop
      // that lines up with the state it belongs to.
      wen_d  = (state_d == WR);
      ren_d  = (state_d == RD);
      ack_d  = (state_d == ACK) || (state_d == ERR);
      err_d  = (state_d == ERR);
      busy_d = (state_d != IDLE);

      // Read data exists only during the ACK that follows RDW; every other
      // cycle (write ACK, ERR, IDLE) sees zero.
      rdata_d = (state_q == RDW) ? reg_rdata_i : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         wen_q   <= 1'b0;
         ren_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         wen_q   <= wen_d;
         ren_q   <= ren_d;
      end
   end

   assign ack_o       = ack_q;
   assign err_o       = err_q;
   assign rdata_o     = rdata_q;
   assign busy_o      = busy_q;
   assign reg_wen_o   = wen_q;
   assign reg_ren_o   = ren_q;
   assign reg_addr_o  = addr_q;
   assign reg_wdata_o = wdata_q;

endmodule

// File: tb/tb_cmt_bus_bridge.sv
// tb/tb_cmt_bus_bridge.sv - self-checking bench for cmt_bus_bridge
module tb_cmt_bus_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_i;
   logic        we_i;
   logic [7:0]  addr_i;
   logic [3:0]  be_i;
   logic [31:0] wdata_i;
   logic        ack_o;
   logic        err_o;
   logic [31:0] rdata_o;
   logic        busy_o;
   logic        reg_wen_o;
   logic        reg_ren_o;
   logic [7:0]  reg_addr_o;
   logic [31:0] reg_wdata_o;
   logic [31:0] reg_rdata_i = '0;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:63] = '{default: '0};
   logic [31:0] sh  [0:7]  = '{default: '0};

   always #5 clk = ~clk;

   cmt_bus_bridge dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req_i),
      .we_i        (we_i),
      .addr_i      (addr_i),
      .be_i        (be_i),
      .wdata_i     (wdata_i),
      .ack_o       (ack_o),
      .err_o       (err_o),
      .rdata_o     (rdata_o),
      .busy_o      (busy_o),
      .reg_wen_o   (reg_wen_o),
      .reg_ren_o   (reg_ren_o),
      .reg_addr_o  (reg_addr_o),
      .reg_wdata_o (reg_wdata_o),
      .reg_rdata_i (reg_rdata_i)
   );

   always @(posedge clk) begin
      if (reg_wen_o) mem[reg_addr_o[7:2]] <= reg_wdata_o;
      if (reg_ren_o) reg_rdata_i <= mem[reg_addr_o[7:2]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Control bits in order {busy, wen, ren, ack, err}.
   task automatic chk_ctl(input string tag, input logic [4:0] exp);
      chk(tag, {27'd0, busy_o, reg_wen_o, reg_ren_o, ack_o, err_o}, {27'd0, exp});
   endtask

   // Called at a negedge in an IDLE cycle; returns at a negedge in an IDLE cycle.
   task automatic txn(input logic we, input logic [7:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, input bit hold, input bit chg,
                      input logic [7:0] chg_addr);
      bit          legal;
      bit          last;
      int          n;
      logic [31:0] exp_rd;
      legal  = (addr % 4 == 0) && (addr <= 8'h18) && (!we || be == 4'hF);
      n      = !legal ? 1 : (we ? 2 : 3);
      exp_rd = (legal && !we) ? sh[addr / 4] : 32'd0;
      if (legal && we) sh[addr / 4] = wd;
      req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wd;
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         last = (c == n);
         chk_ctl($sformatf("ctl a=%0h we=%0b c%0d", addr, we, c),
                 {1'b1, legal && we && c == 1, legal && !we && c == 1, last, last && !legal});
         chk($sformatf("rdata a=%0h c%0d", addr, c), rdata_o, last ? exp_rd : 32'd0);
         if (legal) chk($sformatf("reg_addr a=%0h c%0d", addr, c), {24'd0, reg_addr_o}, {24'd0, addr});
         if (legal && we && c == 1) chk($sformatf("reg_wdata a=%0h", addr), reg_wdata_o, wd);
         if (chg) begin addr_i = chg_addr; wdata_i = ~wd; we_i = ~we; end
         if (last && !hold) req_i = 1'b0;
      end
      @(negedge clk);
      chk_ctl($sformatf("idle ctl a=%0h", addr), 5'b0);
      chk($sformatf("idle rdata a=%0h", addr), rdata_o, 32'd0);
   endtask

   initial begin
      logic       rwe;
      logic [7:0] raddr;
      logic [3:0] rbe;
      rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
      repeat (2) @(negedge clk);
      chk_ctl("reset ctl", 5'b0);
      chk("reset rdata", rdata_o, 32'd0);
      chk("reset reg_addr", {24'd0, reg_addr_o}, 32'd0);
      chk("reset reg_wdata", reg_wdata_o, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Write cmcor0, read it back, illegal accesses.
      txn(1'b1, 8'h14, 4'hF, 32'h0000_1234, 1'b0, 1'b0, 8'h00);
      txn(1'b0, 8'h14, 4'h0, 32'h0, 1'b0, 1'b0, 8'h00);
      txn(1'b0, 8'h1C, 4'hF, 32'h0, 1'b0, 1'b0, 8'h00);
      txn(1'b0, 8'h06, 4'hF, 32'h0, 1'b0, 1'b0, 8'h00);
      txn(1'b1, 8'h10, 4'h3, 32'hDEAD, 1'b0, 1'b0, 8'h00);
      txn(1'b1, 8'h18, 4'hF, 32'hCAFE_0018, 1'b0, 1'b0, 8'h00);
      txn(1'b0, 8'h18, 4'h5, 32'h0, 1'b0, 1'b0, 8'h00);

      // Back-to-back: request held high repeats the write.
      txn(1'b1, 8'h00, 4'hF, 32'd3, 1'b1, 1'b0, 8'h00);
      txn(1'b1, 8'h00, 4'hF, 32'd3, 1'b0, 1'b0, 8'h00);

      // Field changes while busy are ignored.
      txn(1'b1, 8'h0C, 4'hF, 32'hA5A5_0C0C, 1'b0, 1'b0, 8'h00);
      txn(1'b0, 8'h0C, 4'hF, 32'h0, 1'b0, 1'b1, 8'h08);
      txn(1'b0, 8'h08, 4'hF, 32'h0, 1'b0, 1'b0, 8'h00);

      // Reset mid-read.
      req_i = 1'b1; we_i = 1'b0; addr_i = 8'h10; be_i = 4'hF;
      @(negedge clk);
      chk_ctl("rst-mid RD ctl", 5'b10100);
      rst_n = 1'b0; req_i = 1'b0;
      #1;
      chk_ctl("rst-mid asserted ctl", 5'b0);
      chk("rst-mid rdata", rdata_o, 32'd0);
      chk("rst-mid reg_addr", {24'd0, reg_addr_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_ctl($sformatf("rst-mid after %0d", i), 5'b0);
         chk($sformatf("rst-mid rdata after %0d", i), rdata_o, 32'd0);
      end

      // Randomized traffic against the shadow model.
      for (int k = 0; k < 80; k++) begin
         rwe   = 1'($urandom_range(0, 1));
         raddr = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, 6) * 4) : 8'($urandom_range(0, 255));
         rbe   = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
         txn(rwe, raddr, rbe, $urandom, (k != 79) && ($urandom_range(0, 4) == 0),
             1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end
      req_i = 1'b0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
